i2c_slave_ctrl: RTL

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

---
 rtl/i2c_slave_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C target (slave) controller with byte-stream interfaces.
//
// Ports:
//   clock      - sole clock, all logic on rising edge
//   rst        - synchronous active-high reset
//   scl_in     - raw SCL pin level (asynchronous)
//   sda_in     - raw SDA pin level (asynchronous)
//   sda_oe     - 1 pulls SDA low, 0 releases it
//   rx_data    - last byte written by the master
//   rx_vld     - one-cycle pulse when rx_data updates
//   rx_ready   - sink can take a byte; sampled while rx_vld is high
//   tx_data    - next byte to return to the master
//   tx_vld     - tx_data is available
//   tx_ready   - one-cycle pulse when tx_data is consumed
//   busy       - high while this target is addressed (ACK/RX/TX states)
//   err_flags  - [0] rx overflow, [1] tx underrun, [2] master NACK (pulses)
module i2c_slave_ctrl #(
    parameter int              ALEN       = 7,
    parameter logic [ALEN-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_ready,
    output logic       busy,
    output logic [2:0] err_flags
);

    typedef enum logic [2:0] {
        SIDLE, GET_ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    logic       scl_s1_q, scl_s2_q, scl_h_q;
    logic       sda_s1_q, sda_s2_q, sda_h_q;
    logic       rise_q, fall_q, start_q, stop_q, sda_bit_q;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [7:0] shift_q;
    logic       rw_q, rdy_q, done_q;
    logic       sda_oe_q, rx_vld_q, tx_ready_q;
    logic [7:0] rx_data_q;
    logic [2:0] err_q;

    logic [7:0] byte_in;
    logic [7:0] tx_load;

    assign byte_in = {shift_q[6:0], sda_bit_q};
    // An empty transmit source is answered with all ones (SDA released).
    assign tx_load = tx_vld ? tx_data : 8'hFF;

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_vld    = rx_vld_q;
    assign tx_ready  = tx_ready_q;
    assign err_flags = err_q;
    assign busy      = (state_q == ADDR_ACK) || (state_q == RX_BYTE) ||
                       (state_q == RX_ACK)   || (state_q == TX_BYTE) ||
                       (state_q == TX_ACK);

    // Synchronisers reset to 1 so an idle-high bus never looks like a START
    // when reset is released. Bus events are registered, giving a fixed
    // 4-clock pin-to-sda_oe latency.
    always_ff @(posedge clock) begin
        if (rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_h_q   <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_h_q   <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            sda_bit_q <= 1'b1;
        end else begin
            scl_s1_q  <= scl_in;
            scl_s2_q  <= scl_s1_q;
            scl_h_q   <= scl_s2_q;
            sda_s1_q  <= sda_in;
            sda_s2_q  <= sda_s1_q;
            sda_h_q   <= sda_s2_q;
            rise_q    <= scl_s2_q & ~scl_h_q;
            fall_q    <= ~scl_s2_q & scl_h_q;
            start_q   <= scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
            stop_q    <= scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
            sda_bit_q <= sda_s2_q;
        end
    end

    // In the ACK states sda_oe_q doubles as the phase bit: the first SCL fall
    // asserts the ACK, the second one ends it.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= SIDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_vld_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            err_q      <= 3'b000;
        end else begin
            rx_vld_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            err_q      <= 3'b000;
            if (rx_vld_q) rdy_q <= rx_ready;

            if (start_q) begin
                state_q  <= GET_ADDR;
                cnt_q    <= 3'd0;
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else if (stop_q) begin
                state_q  <= SIDLE;
                cnt_q    <= 3'd0;
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    SIDLE: ;
                    GET_ADDR: if (rise_q) begin
                        shift_q <= byte_in;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                rw_q    <= byte_in[0];
                                state_q <= ADDR_ACK;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: if (fall_q) begin
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else if (rw_q) begin
                            sda_oe_q   <= ~tx_load[7];
                            shift_q    <= {tx_load[6:0], 1'b0};
                            tx_ready_q <= tx_vld;
                            err_q[1]   <= ~tx_vld;
                            cnt_q      <= 3'd0;
                            done_q     <= 1'b0;
                            state_q    <= TX_BYTE;
                        end else begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 3'd0;
                            state_q  <= RX_BYTE;
                        end
                    end
                    RX_BYTE: if (rise_q) begin
                        shift_q <= byte_in;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_q <= byte_in;
                            rx_vld_q  <= 1'b1;
                            state_q   <= RX_ACK;
                        end
                    end
                    RX_ACK: if (fall_q) begin
                        if (sda_oe_q) begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 3'd0;
                            state_q  <= RX_BYTE;
                        end else if (rdy_q) begin
                            sda_oe_q <= 1'b1;
                        end else begin
                            err_q[0] <= 1'b1;
                            state_q  <= WAIT_STOP;
                        end
                    end
                    TX_BYTE: begin
                        if (rise_q) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) done_q <= 1'b1;
                        end else if (fall_q) begin
                            if (done_q) begin
                                sda_oe_q <= 1'b0;
                                done_q   <= 1'b0;
                                state_q  <= TX_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[7];
                                shift_q  <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (rise_q && sda_bit_q) begin
                            err_q[2] <= 1'b1;
                            state_q  <= WAIT_STOP;
                        end else if (fall_q) begin
                            sda_oe_q   <= ~tx_load[7];
                            shift_q    <= {tx_load[6:0], 1'b0};
                            tx_ready_q <= tx_vld;
                            err_q[1]   <= ~tx_vld;
                            cnt_q      <= 3'd0;
                            state_q    <= TX_BYTE;
                        end
                    end
                    WAIT_STOP: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

endmodule
